// File: rtl/calc_pkg.sv
// Shared types for the calculator port engine: command/response encodings
// and the response record carried through the pipes and FIFO.
package calc_pkg;
  localparam int CALC_CMD_WIDTH  = 4;
  localparam int CALC_DATA_WIDTH = 32;

  typedef enum logic [CALC_CMD_WIDTH-1:0] {
    NOP = CALC_CMD_WIDTH'(0),
    ADD = CALC_CMD_WIDTH'(1),
    SUB = CALC_CMD_WIDTH'(2),
    SHL = CALC_CMD_WIDTH'(5),
    SHR = CALC_CMD_WIDTH'(6)
  } calc_cmd_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    OK      = 2'd1,
    OVF     = 2'd2,
    INVALID = 2'd3
  } calc_resp_e;

  typedef struct packed {
    calc_resp_e                 resp;
    logic [CALC_DATA_WIDTH-1:0] data;
    logic [1:0]                 tag;
  } calc_rsp_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP2  = 1'b1
  } calc_state_e;
endpackage

// File: rtl/calc_rsp_fifo.sv
// Response FIFO with two write slots per cycle (slot0 lands first) and one
// read; writes that find no room are discarded and latch a sticky drop flag.
module calc_rsp_fifo
  import calc_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = calc_rsp_t
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_wr0_en,
  input  T     i_wr0_data,
  input  logic i_wr1_en,
  input  T     i_wr1_data,
  input  logic i_rd_en,
  output T     o_rd_data,
  output logic o_empty,
  output logic o_drop
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T               r_mem [2**PW];
  logic [PW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_drop;

  logic           w_pop, w_acc0, w_acc1;
  logic [PW-1:0]  w_wr1_ptr;
  int             w_free;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // A same-cycle pop frees its slot for the incoming writes.
  always_comb begin
    w_pop     = i_rd_en && (r_count != '0);
    w_free    = DEPTH - int'(r_count) + int'(w_pop);
    w_acc0    = i_wr0_en && (w_free >= 1);
    w_acc1    = i_wr1_en && (w_free >= (w_acc0 ? 2 : 1));
    w_wr1_ptr = w_acc0 ? nxt(r_wptr) : r_wptr;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      if (w_acc0 && w_acc1)    r_wptr <= nxt(nxt(r_wptr));
      else if (w_acc0 || w_acc1) r_wptr <= nxt(r_wptr);
      if (w_pop) r_rptr <= nxt(r_rptr);
      r_count <= r_count + CW'(w_acc0) + CW'(w_acc1) - CW'(w_pop);
      if ((i_wr0_en && !w_acc0) || (i_wr1_en && !w_acc1)) r_drop <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_acc0) r_mem[r_wptr]    <= i_wr0_data;
    if (w_acc1) r_mem[w_wr1_ptr] <= i_wr1_data;
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_empty   = (r_count == '0);
  assign o_drop    = r_drop;
endmodule

// File: rtl/calc_port_engine.sv
// One calculator port: two-cycle request capture, add/sub and shift
// fixed-latency pipes, and a response FIFO draining one response per cycle.
module calc_port_engine
  import calc_pkg::*;
#(
  parameter int ADD_LAT        = 1,
  parameter int SHIFT_LAT      = 3,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                       PClk,
  input  logic                       Rst,
  input  logic [CALC_CMD_WIDTH-1:0]  req_cmd_in,
  input  logic [CALC_DATA_WIDTH-1:0] req_data_in,
  input  logic [1:0]                 req_tag_in,
  output logic [1:0]                 out_resp,
  output logic [CALC_DATA_WIDTH-1:0] out_data,
  output logic [1:0]                 out_tag,
  output logic                       err_drop
);
  calc_state_e                r_state, w_state_nxt;
  logic                       w_capture, w_dispatch, w_is_shift;
  logic [CALC_CMD_WIDTH-1:0]  r_cmd;
  logic [CALC_DATA_WIDTH-1:0] r_op1;
  logic [1:0]                 r_tag;
  calc_rsp_t                  w_result;

  logic [ADD_LAT-1:0]         r_add_vld;
  calc_rsp_t                  r_add_pipe [ADD_LAT];
  logic [SHIFT_LAT-1:0]       r_sh_vld;
  calc_rsp_t                  r_sh_pipe  [SHIFT_LAT];

  calc_rsp_t                  w_fifo_head, r_out;
  logic                       w_fifo_empty;

  function automatic calc_rsp_t calc_exec(input logic [CALC_CMD_WIDTH-1:0]  cmd,
                                          input logic [CALC_DATA_WIDTH-1:0] op1,
                                          input logic [CALC_DATA_WIDTH-1:0] op2,
                                          input logic [1:0]                 tag);
    calc_rsp_t                  r;
    logic [CALC_DATA_WIDTH:0]   sum;
    sum    = {1'b0, op1} + {1'b0, op2};
    r.tag  = tag;
    r.resp = OK;
    r.data = '0;
    case (cmd)
      ADD:     if (sum[CALC_DATA_WIDTH]) r.resp = OVF; else r.data = sum[CALC_DATA_WIDTH-1:0];
      SUB:     if (op1 < op2) r.resp = OVF; else r.data = op1 - op2;
      SHL:     r.data = op1 << op2[4:0];
      SHR:     r.data = op1 >> op2[4:0];
      default: r.resp = INVALID;
    endcase
    return r;
  endfunction

  always_ff @(posedge PClk) begin
    if (!Rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_dispatch  = 1'b0;
    case (r_state)
      ST_IDLE: if (req_cmd_in != '0) begin
        w_capture   = 1'b1;
        w_state_nxt = ST_OP2;
      end
      ST_OP2: begin
        w_dispatch  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PClk) begin
    if (w_capture) begin
      r_cmd <= req_cmd_in;
      r_op1 <= req_data_in;
      r_tag <= req_tag_in;
    end
  end

  // Dispatch edge: result is final here; the pipes only model latency.
  assign w_is_shift = (r_cmd == SHL) || (r_cmd == SHR);
  assign w_result   = calc_exec(r_cmd, r_op1, req_data_in, r_tag);

  always_ff @(posedge PClk) begin
    if (!Rst) begin
      r_add_vld <= '0;
      r_sh_vld  <= '0;
    end else begin
      r_add_vld[0] <= w_dispatch && !w_is_shift;
      r_sh_vld[0]  <= w_dispatch && w_is_shift;
      for (int i = 1; i < ADD_LAT; i++)   r_add_vld[i] <= r_add_vld[i-1];
      for (int i = 1; i < SHIFT_LAT; i++) r_sh_vld[i]  <= r_sh_vld[i-1];
    end
  end

  always_ff @(posedge PClk) begin
    r_add_pipe[0] <= w_result;
    r_sh_pipe[0]  <= w_result;
    for (int i = 1; i < ADD_LAT; i++)   r_add_pipe[i] <= r_add_pipe[i-1];
    for (int i = 1; i < SHIFT_LAT; i++) r_sh_pipe[i]  <= r_sh_pipe[i-1];
  end

  // Pipe exits: add pipe takes slot0 so it wins on simultaneous completion.
  calc_rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH),
    .T     (calc_rsp_t)
  ) u_rsp_fifo (
    .i_clk      (PClk),
    .i_rst_n    (Rst),
    .i_wr0_en   (r_add_vld[ADD_LAT-1]),
    .i_wr0_data (r_add_pipe[ADD_LAT-1]),
    .i_wr1_en   (r_sh_vld[SHIFT_LAT-1]),
    .i_wr1_data (r_sh_pipe[SHIFT_LAT-1]),
    .i_rd_en    (1'b1),
    .o_rd_data  (w_fifo_head),
    .o_empty    (w_fifo_empty),
    .o_drop     (err_drop)
  );

  // Output stage: zeroed whenever no response is presented.
  always_ff @(posedge PClk) begin
    if (!Rst)              r_out <= '0;
    else if (w_fifo_empty) r_out <= '0;
    else                   r_out <= w_fifo_head;
  end

  assign out_resp = r_out.resp;
  assign out_data = r_out.data;
  assign out_tag  = r_out.tag;
endmodule
